move_sequencer: RTL and testbench

Parametrised fighter-animation sequencer for the player sprite. It turns the J/K press inputs into a move (idle, punch, combo, fail) and a frame index within that move, which feed the sprite ROM address logic. Animation advances on a per-frame display tick, and each frame is held for a programmable number of ticks. The combo is gated on both keys being held, with a real fail path, and a saturating streak counter tracks completed combos.

---
 rtl/move_sequencer_if.sv | 31 +++
 rtl/move_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_move_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// move_sequencer_if
// Purpose : groups the per-frame tick, key levels and animation outputs of the
//           player-sprite move sequencer into one bundle.
// Signals : Frame_Tick, J_Press, K_Press  - driven by the master (video/input side)
//           Move, Frame, Busy, Combo_Done,
//           Fail, Hit_Count               - driven by the slave (the sequencer)
// Modports: master = stimulus / consumer side, slave = move_sequencer.
interface move_sequencer_if #(
  parameter int FRAME_W = 4,
  parameter int CNT_W   = 8
);
  logic               Frame_Tick;
  logic               J_Press;
  logic               K_Press;
  logic [1:0]         Move;
  logic [FRAME_W-1:0] Frame;
  logic               Busy;
  logic               Combo_Done;
  logic               Fail;
  logic [CNT_W-1:0]   Hit_Count;

  modport master (
    output Frame_Tick, J_Press, K_Press,
    input  Move, Frame, Busy, Combo_Done, Fail, Hit_Count
  );

  modport slave (
    input  Frame_Tick, J_Press, K_Press,
    output Move, Frame, Busy, Combo_Done, Fail, Hit_Count
  );
endinterface

// File: rtl/move_sequencer.sv
// move_sequencer
// Purpose : turns J/K key levels into a fighter move (idle/punch/combo/fail)
//           and a frame index for the sprite ROM. State advances only on
//           Frame_Tick; each frame lasts TICKS_PER_FRAME ticks. The combo
//           needs both keys held at every advance out of a gated frame, and a
//           saturating streak counter counts completed combos.
// Ports   : Clk   - system clock
//           Reset - asynchronous, active-high reset
//           bus   - move_sequencer_if.slave (Frame_Tick, J_Press, K_Press in;
//                   Move, Frame, Busy, Combo_Done, Fail, Hit_Count out)
module move_sequencer #(
  parameter int FRAMES_PUNCH    = 3,
  parameter int FRAMES_COMBO    = 10,
  parameter int COMBO_GATE      = 8,
  parameter int FRAMES_FAIL     = 3,
  parameter int TICKS_PER_FRAME = 4,
  parameter int FRAME_W         = 4,
  parameter int CNT_W           = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  move_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PUNCH = 3'd1,
    ST_COMBO = 3'd2,
    ST_FAIL  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  localparam int TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_FRAME - 1);
  localparam logic [FRAME_W-1:0] PUNCH_LAST = FRAME_W'(FRAMES_PUNCH - 1);
  localparam logic [FRAME_W-1:0] COMBO_LAST = FRAME_W'(FRAMES_COMBO - 1);
  localparam logic [FRAME_W-1:0] FAIL_LAST  = FRAME_W'(FRAMES_FAIL - 1);
  localparam logic [CNT_W-1:0]   HIT_MAX    = {CNT_W{1'b1}};

  state_t             state_r, state_s;
  logic [TICK_W-1:0]  tick_r, tick_s;
  logic [FRAME_W-1:0] frame_r, frame_s;
  logic [CNT_W-1:0]   hit_r, hit_s;
  logic               done_r, done_s;
  logic               fail_r, fail_s;
  logic [1:0]         move_r, move_s;
  logic               busy_r, busy_s;
  logic               advance_s;
  logic               both_s;

  // Next-state, counter and pulse logic; everything holds unless Frame_Tick is high.
  always_comb begin
    state_s   = state_r;
    tick_s    = tick_r;
    frame_s   = frame_r;
    hit_s     = hit_r;
    done_s    = 1'b0;
    fail_s    = 1'b0;
    advance_s = bus.Frame_Tick && (tick_r == TICK_LAST);
    both_s    = bus.J_Press & bus.K_Press;
    if (bus.Frame_Tick) begin
      case (state_r)
        ST_IDLE: begin
          tick_s  = '0;
          frame_s = '0;
          if (both_s) begin
            state_s = ST_COMBO;
          end else if (bus.J_Press) begin
            state_s = ST_PUNCH;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_PUNCH: begin
          if (advance_s) begin
            tick_s = '0;
            if (frame_r == PUNCH_LAST) begin
              state_s = ST_HOLD;
              frame_s = '0;
            end else begin
              frame_s = frame_r + FRAME_W'(1);
            end
          end else begin
            tick_s = tick_r + TICK_W'(1);
          end
        end
        ST_COMBO: begin
          if (advance_s) begin
            tick_s = '0;
            // The gate check comes first so a gate covering the last frame still fails.
            if ((int'(frame_r) < COMBO_GATE) && !both_s) begin
              state_s = ST_FAIL;
              frame_s = '0;
              fail_s  = 1'b1;
              hit_s   = '0;
            end else if (frame_r == COMBO_LAST) begin
              state_s = ST_HOLD;
              frame_s = '0;
              done_s  = 1'b1;
              hit_s   = (hit_r == HIT_MAX) ? hit_r : hit_r + CNT_W'(1);
            end else begin
              frame_s = frame_r + FRAME_W'(1);
            end
          end else begin
            tick_s = tick_r + TICK_W'(1);
          end
        end
        ST_FAIL: begin
          if (advance_s) begin
            tick_s = '0;
            if (frame_r == FAIL_LAST) begin
              state_s = ST_HOLD;
              frame_s = '0;
            end else begin
              frame_s = frame_r + FRAME_W'(1);
            end
          end else begin
            tick_s = tick_r + TICK_W'(1);
          end
        end
        ST_HOLD: begin
          // Keys must be fully released before another move can start.
          tick_s  = '0;
          frame_s = '0;
          if (bus.J_Press | bus.K_Press) begin
            state_s = ST_HOLD;
          end else begin
            state_s = ST_IDLE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          tick_s  = '0;
          frame_s = '0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Decode the upcoming state into the Move code and Busy flag so both are registered.
  always_comb begin
    move_s = 2'd0;
    busy_s = 1'b0;
    case (state_s)
      ST_PUNCH: begin move_s = 2'd1; busy_s = 1'b1; end
      ST_COMBO: begin move_s = 2'd2; busy_s = 1'b1; end
      ST_FAIL:  begin move_s = 2'd3; busy_s = 1'b1; end
      default:  begin move_s = 2'd0; busy_s = 1'b0; end
    endcase
  end

  // State, counter and output registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      tick_r  <= '0;
      frame_r <= '0;
      hit_r   <= '0;
      done_r  <= 1'b0;
      fail_r  <= 1'b0;
      move_r  <= 2'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      tick_r  <= tick_s;
      frame_r <= frame_s;
      hit_r   <= hit_s;
      done_r  <= done_s;
      fail_r  <= fail_s;
      move_r  <= move_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.Move       = move_r;
  assign bus.Frame      = frame_r;
  assign bus.Busy       = busy_r;
  assign bus.Combo_Done = done_r;
  assign bus.Fail       = fail_r;
  assign bus.Hit_Count  = hit_r;

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer
// Purpose : directed self-checking bench for move_sequencer (CNT_W = 2 so the
//           streak counter saturates quickly; other parameters default).
//           Each Frame_Tick step pushes its expected outputs to a queue; the
//           entry is popped and compared once the DUT has registered the tick.
module tb_move_sequencer;

  typedef struct packed {
    logic [1:0] move;
    logic [3:0] frame;
    logic       busy;
    logic       done;
    logic       fail;
    logic [1:0] hit;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  logic [1:0] h;

  always #5 Clk = ~Clk;

  move_sequencer_if #(.FRAME_W(4), .CNT_W(2)) bus ();

  move_sequencer #(.CNT_W(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  function automatic exp_t mk(input logic [1:0] m, input int f, input logic d,
                              input logic fl, input logic [1:0] hc);
    exp_t e;
    e.move  = m;
    e.frame = 4'(f);
    e.busy  = (m != 2'd0);
    e.done  = d;
    e.fail  = fl;
    e.hit   = hc;
    return e;
  endfunction

  task automatic check(input string tag, input exp_t e);
    exp_t obs;
    obs = {bus.Move, bus.Frame, bus.Busy, bus.Combo_Done, bus.Fail, bus.Hit_Count};
    n_checks++;
    assert (obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // One Frame_Tick with the given keys, then one non-tick cycle with the keys
  // inverted: pulses must drop and everything else must hold.
  task automatic step(input logic j, input logic k, input exp_t e, input string tag);
    exp_t held;
    exp_q.push_back(e);
    @(negedge Clk);
    bus.Frame_Tick = 1'b1;
    bus.J_Press    = j;
    bus.K_Press    = k;
    @(negedge Clk);
    bus.Frame_Tick = 1'b0;
    bus.J_Press    = ~j;
    bus.K_Press    = ~k;
    check(tag, exp_q.pop_front());
    held      = e;
    held.done = 1'b0;
    held.fail = 1'b0;
    @(negedge Clk);
    check({tag, "_nontick"}, held);
  endtask

  // Full combo: 40 ticks in COMBO, then the completing tick into HOLD.
  // rel_frame >= 0 releases both keys after the advance into that frame.
  task automatic combo_ok(input logic [1:0] h0, input int rel_frame, input string tag,
                          output logic [1:0] h1);
    logic kk;
    for (int i = 0; i < 40; i++) begin
      kk = (rel_frame < 0) || (i <= 4 * rel_frame);
      step(kk, kk, mk(2'd2, i / 4, 1'b0, 1'b0, h0), tag);
    end
    h1 = (h0 == 2'd3) ? 2'd3 : h0 + 2'd1;
    kk = (rel_frame < 0);
    step(kk, kk, mk(2'd0, 0, 1'b1, 1'b0, h1), {tag, "_done"});
  endtask

  initial begin
    Reset          = 1'b1;
    bus.Frame_Tick = 1'b0;
    bus.J_Press    = 1'b0;
    bus.K_Press    = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset", mk(2'd0, 0, 1'b0, 1'b0, 2'd0));
    Reset = 1'b0;

    // K alone or no key leaves IDLE alone.
    step(1'b0, 1'b1, mk(2'd0, 0, 1'b0, 1'b0, 2'd0), "k_only_idle");
    step(1'b0, 1'b0, mk(2'd0, 0, 1'b0, 1'b0, 2'd0), "no_key_idle");

    // Punch: 3 frames x 4 ticks, then HOLD; J held in HOLD keeps it there.
    for (int i = 0; i < 12; i++)
      step(i == 0, 1'b0, mk(2'd1, i / 4, 1'b0, 1'b0, 2'd0), "punch");
    step(1'b0, 1'b0, mk(2'd0, 0, 1'b0, 1'b0, 2'd0), "punch_to_hold");
    step(1'b1, 1'b0, mk(2'd0, 0, 1'b0, 1'b0, 2'd0), "hold_with_j");
    step(1'b0, 1'b0, mk(2'd0, 0, 1'b0, 1'b0, 2'd0), "hold_to_idle");

    // Full combo, keys held in HOLD, then release to IDLE.
    combo_ok(2'd0, -1, "combo", h);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, mk(2'd0, 0, 1'b0, 1'b0, 2'd1), "hold_keys");
    step(1'b0, 1'b0, mk(2'd0, 0, 1'b0, 1'b0, 2'd1), "combo_idle");

    // Combo fail: K dips on non-advance ticks 6 and 15 (ignored), then is
    // low on tick 16, the advance out of frame 3.
    for (int i = 0; i < 16; i++)
      step(1'b1, !((i == 6) || (i == 15)), mk(2'd2, i / 4, 1'b0, 1'b0, 2'd1), "combo_pre_fail");
    step(1'b1, 1'b0, mk(2'd3, 0, 1'b0, 1'b1, 2'd0), "fail_enter");
    for (int i = 17; i < 28; i++)
      step(1'b0, 1'b0, mk(2'd3, (i - 16) / 4, 1'b0, 1'b0, 2'd0), "fail_frames");
    step(1'b0, 1'b1, mk(2'd0, 0, 1'b0, 1'b0, 2'd0), "fail_to_hold");
    step(1'b1, 1'b0, mk(2'd0, 0, 1'b0, 1'b0, 2'd0), "fail_hold");
    step(1'b0, 1'b0, mk(2'd0, 0, 1'b0, 1'b0, 2'd0), "fail_idle");

    // Release during frame 8 (past the gate): the combo still completes.
    combo_ok(2'd0, 8, "post_gate", h);
    step(1'b0, 1'b0, mk(2'd0, 0, 1'b0, 1'b0, h), "post_gate_idle");

    // Four more combos: streak goes 2, 3, 3, 3.
    for (int c = 0; c < 4; c++) begin
      combo_ok(h, -1, "sat", h);
      step(1'b0, 1'b0, mk(2'd0, 0, 1'b0, 1'b0, h), "sat_idle");
    end

    // Reset asynchronously in COMBO frame 5, away from any clock edge.
    for (int i = 0; i < 21; i++)
      step(1'b1, 1'b1, mk(2'd2, i / 4, 1'b0, 1'b0, 2'd3), "pre_reset");
    #3;
    Reset = 1'b1;
    #1;
    check("reset_async", mk(2'd0, 0, 1'b0, 1'b0, 2'd0));
    @(negedge Clk);
    Reset       = 1'b0;
    bus.J_Press = 1'b1;
    bus.K_Press = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("frozen_no_tick", mk(2'd0, 0, 1'b0, 1'b0, 2'd0));
    end
    step(1'b1, 1'b0, mk(2'd1, 0, 1'b0, 1'b0, 2'd0), "after_reset_punch");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
